// File: rtl/hack_exec_ctrl.sv
// hack_exec_ctrl -- multi-cycle Hack CPU control/datapath stage.
//
// Holds the A, D and PC registers, fetches one 16-bit instruction at a time,
// optionally reads M from data memory, drives the external Hack ALU and
// consumes its result to write back A/D/M and resolve jumps.
//
// Parameters
//   PC_W      program counter / data address width (<= 16)
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clock, reset_n          clock and asynchronous active-low reset
//   inst, inst_valid        instruction word from ROM and its valid flag
//   inst_ready              stage accepts an instruction this cycle
//   pc                      address of the next instruction to fetch
//   mem_rd, in_m, m_valid   data read request, read data, read completion
//   address_m, out_m        data memory address (A) and write value (alu_out)
//   write_m                 one-cycle data memory write strobe
//   x, y                    ALU operands (x = D, y = IR[12] ? M : A)
//   zx, nx, zy, ny, f, no   ALU control bits = IR[11:6]
//   alu_out, zr, ng         ALU result and flags
//   cyc_cnt, ret_cnt        cycle / retired-instruction counters (optional)
//   dbg_state_o             FSM state: 0 = FETCH, 1 = MREAD, 2 = EXEC
//
// Handshakes: an instruction transfers on a rising edge where inst_valid and
// inst_ready are both 1; inst_ready does not depend on inst_valid, and the
// source must hold inst stable while inst_valid is high and not yet accepted.
// A read transfers on the edge where mem_rd and m_valid are both 1; mem_rd is
// held high until then, so the memory may stall indefinitely.
//
// Configuration
//   HACK_EXEC_PERF_EN  when defined, adds the cyc_cnt / ret_cnt counters.

module hack_exec_ctrl #(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [15:0]     inst,
  input  logic            inst_valid,
  output logic            inst_ready,
  output logic [PC_W-1:0] pc,
  output logic            mem_rd,
  input  logic [15:0]     in_m,
  input  logic            m_valid,
  output logic [PC_W-1:0] address_m,
  output logic [15:0]     out_m,
  output logic            write_m,
  output logic [15:0]     x,
  output logic [15:0]     y,
  output logic            zx,
  output logic            nx,
  output logic            zy,
  output logic            ny,
  output logic            f,
  output logic            no,
  input  logic [15:0]     alu_out,
  input  logic            zr,
  input  logic            ng,
`ifdef HACK_EXEC_PERF_EN
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     ret_cnt,
`endif
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MREAD = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t          state_q;
  logic [15:0]     a_q, d_q, ir_q, m_q;
  logic [PC_W-1:0] pc_q;
  logic            rdy_q, mrd_q, wr_q;
  logic            accept;
  logic            take;
  logic            unused_ir;

  assign accept = (state_q == S_FETCH) && rdy_q && inst_valid;

  // Jump decision uses the flags of the ALU result produced in EXEC.
  assign take = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);

  // IR[15] is implied by reaching EXEC; IR[14:13] carry no meaning.
  assign unused_ir = ^ir_q[15:13];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      m_q     <= '0;
      pc_q    <= RESET_PC;
      rdy_q   <= 1'b0;
      mrd_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          rdy_q <= 1'b1;
          if (accept) begin
            ir_q <= inst;
            if (!inst[15]) begin
              a_q  <= inst;
              pc_q <= pc_q + PC_W'(1);
            end else if (inst[12]) begin
              state_q <= S_MREAD;
              rdy_q   <= 1'b0;
              mrd_q   <= 1'b1;
            end else begin
              state_q <= S_EXEC;
              rdy_q   <= 1'b0;
              wr_q    <= inst[3];
            end
          end
        end
        S_MREAD: begin
          if (m_valid) begin
            m_q     <= in_m;
            mrd_q   <= 1'b0;
            wr_q    <= ir_q[3];
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Jump target and write address both use A before this update.
          if (ir_q[5]) a_q <= alu_out;
          if (ir_q[4]) d_q <= alu_out;
          pc_q    <= take ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
          wr_q    <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= S_FETCH;
        end
        default: begin
          state_q <= S_FETCH;
          rdy_q   <= 1'b1;
          mrd_q   <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign inst_ready  = rdy_q;
  assign mem_rd      = mrd_q;
  assign write_m     = wr_q;
  assign pc          = pc_q;
  assign address_m   = a_q[PC_W-1:0];
  assign out_m       = alu_out;
  assign x           = d_q;
  assign y           = ir_q[12] ? m_q : a_q;
  assign zx          = ir_q[11];
  assign nx          = ir_q[10];
  assign zy          = ir_q[9];
  assign ny          = ir_q[8];
  assign f           = ir_q[7];
  assign no          = ir_q[6];
  assign dbg_state_o = state_q;

`ifdef HACK_EXEC_PERF_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      // An A-instruction retires at fetch, a C-instruction at the end of EXEC.
      if ((accept && !inst[15]) || state_q == S_EXEC) ret_q <= ret_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hack_exec_ctrl.sv
module tb_hack_exec_ctrl;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_MREAD = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [14:0] pc;
  logic        mem_rd;
  logic [15:0] in_m = '0;
  logic        m_valid = 1'b0;
  logic [14:0] address_m;
  logic [15:0] out_m;
  logic        write_m;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] alu_out;
  logic        zr, ng;
  logic [1:0]  dbg_state;
`ifdef HACK_EXEC_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cycles;
    int          rd_cycles;
    int          wr_cnt;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  ctl;
  } obs_t;

  // Reference architectural state.
  logic [15:0] ma, md, mlat, mir;
  logic [14:0] mpc;
  logic [30:0] exp_q[$];

  hack_exec_ctrl dut (
    .clock(clock), .reset_n(reset_n), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pc(pc), .mem_rd(mem_rd), .in_m(in_m),
    .m_valid(m_valid), .address_m(address_m), .out_m(out_m), .write_m(write_m),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_out(alu_out), .zr(zr), .ng(ng),
`ifdef HACK_EXEC_PERF_EN
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Hack ALU (environment) ----------------
  function automatic logic [15:0] hack_alu(input logic [15:0] xv, input logic [15:0] yv,
                                           input logic [5:0] c);
    logic [15:0] a, b, r;
    a = c[5] ? 16'h0000 : xv;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0000 : yv;
    if (c[2]) b = ~b;
    r = c[1] ? a + b : a & b;
    if (c[0]) r = ~r;
    return r;
  endfunction

  assign alu_out = hack_alu(x, y, {zx, nx, zy, ny, f, no});
  assign zr      = (alu_out == 16'h0000);
  assign ng      = alu_out[15];

  // ---------------- reference model ----------------
  task automatic model_reset();
    ma = '0; md = '0; mlat = '0; mir = '0; mpc = '0;
  endtask

  task automatic model_exec(input logic [15:0] ins, input int mdelay,
                            input logic [15:0] mdata, output obs_t e);
    logic [15:0] yv, r;
    logic        z, n, tk;
    e = '{default: 0};
    mir = ins;
    if (!ins[15]) begin
      ma = ins;
      mpc = mpc + 15'd1;
      e.cycles = 1;
    end else begin
      if (ins[12]) mlat = mdata;
      yv = ins[12] ? mdata : ma;
      r  = hack_alu(md, yv, ins[11:6]);
      z  = (r == 16'h0000);
      n  = r[15];
      tk = (ins[2] && n) || (ins[1] && z) || (ins[0] && !n && !z);
      e.cycles    = ins[12] ? 3 + mdelay : 2;
      e.rd_cycles = ins[12] ? mdelay + 1 : 0;
      e.ctl       = ins[11:6];
      if (ins[3]) begin
        e.wr_cnt  = 1;
        e.wr_addr = ma[14:0];
        e.wr_data = r;
      end
      mpc = tk ? ma[14:0] : mpc + 15'd1;
      if (ins[5]) ma = r;
      if (ins[4]) md = r;
    end
  endtask

  // ---------------- driver ----------------
  // Issues one instruction and follows it until the stage is ready again.
  // m_valid is withheld for mdelay cycles of mem_rd, then given with mdata.
  task automatic run_instr(input logic [15:0] ins, input int mdelay,
                           input logic [15:0] mdata, output obs_t o);
    int guard;
    o = '{default: 0};
    guard = 0;
    while (!inst_ready && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!inst_ready) begin
      errors++; checks++;
      $display("FAIL ready_timeout: inst_ready=%0b required=1", inst_ready);
      return;
    end
    inst = ins;
    inst_valid = 1'b1;
    @(posedge clock); #1;
    inst_valid = 1'b0;
    inst = 16'($urandom);
    o.cycles = 1;
    while (!inst_ready && o.cycles < 60) begin
      if (mem_rd) begin
        o.rd_cycles++;
        if (o.rd_cycles > mdelay) begin
          m_valid = 1'b1;
          in_m = mdata;
        end
      end
      if (dbg_state == ST_EXEC) o.ctl = {zx, nx, zy, ny, f, no};
      if (write_m) begin
        o.wr_cnt++;
        o.wr_addr = address_m;
        o.wr_data = out_m;
      end
      @(posedge clock); #1;
      m_valid = 1'b0;
      in_m = 16'($urandom);
      o.cycles++;
    end
    if (!inst_ready) begin
      errors++; checks++;
      $display("FAIL complete_timeout: inst 0x%04h cycles=%0d", ins, o.cycles);
    end
  endtask

  task automatic issue(input logic [15:0] ins, input int mdelay,
                       input logic [15:0] mdata, output obs_t o, output obs_t e);
    run_instr(ins, mdelay, mdata, o);
    model_exec(ins, mdelay, mdata, e);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t o, e;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", inst_ready); end
    checks++; if (write_m !== 1'b0) begin errors++; $display("FAIL rst_write_m: got %0b want 0", write_m); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd: got %0b want 0", mem_rd); end
    reset_n = 1'b1;
    @(posedge clock); #1;
    model_reset();
    checks++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b want 1", inst_ready); end
    checks++; if (dbg_state !== ST_FETCH) begin errors++; $display("FAIL post_rst_state: got %0d want %0d", dbg_state, ST_FETCH); end
    checks++; if (pc !== 15'd0) begin errors++; $display("FAIL post_rst_pc: got %0h want 0", pc); end
    checks++; if (x !== 16'd0 || y !== 16'd0) begin errors++; $display("FAIL post_rst_ad: x=%0h y=%0h want 0", x, y); end

    // Build some state, then abort a C-instruction while it waits in MREAD.
    issue(16'd5, 0, 16'h0, o, e);
    issue(16'hEC10, 0, 16'h0, o, e);
    inst = 16'hFC10;
    inst_valid = 1'b1;
    @(posedge clock); #1;
    inst_valid = 1'b0;
    @(posedge clock); #1;
    checks++; if (mem_rd !== 1'b1 || dbg_state !== ST_MREAD) begin errors++; $display("FAIL mread_wait: mem_rd=%0b state=%0d want 1/%0d", mem_rd, dbg_state, ST_MREAD); end
    reset_n = 1'b0;
    #2;
    checks++; if (mem_rd !== 1'b0 || write_m !== 1'b0 || inst_ready !== 1'b0) begin errors++; $display("FAIL abort_outputs: mem_rd=%0b write_m=%0b ready=%0b want 0/0/0", mem_rd, write_m, inst_ready); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    model_reset();
    checks++; if (dbg_state !== ST_FETCH) begin errors++; $display("FAIL abort_state: got %0d want %0d", dbg_state, ST_FETCH); end
    checks++; if (pc !== 15'd0 || x !== 16'd0 || address_m !== 15'd0) begin errors++; $display("FAIL abort_regs: pc=%0h D=%0h A=%0h want 0", pc, x, address_m); end
    checks++; if (write_m !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL abort_strobes: write_m=%0b mem_rd=%0b want 0", write_m, mem_rd); end
  endtask

  task automatic test_d_eq_a();
    obs_t o, e;
    issue(16'd5, 0, 16'h0, o, e);
    checks++; if (o.cycles !== 1 || pc !== 15'd1) begin errors++; $display("FAIL a_instr: cycles=%0d pc=%0h want 1/1", o.cycles, pc); end
    issue(16'hEC10, 0, 16'h0, o, e);
    checks++; if (x !== 16'd5) begin errors++; $display("FAIL d_eq_a_D: got %0h want 5", x); end
    checks++; if (o.ctl !== 6'b110000) begin errors++; $display("FAIL d_eq_a_ctl: got %b want 110000", o.ctl); end
    checks++; if (pc !== 15'd2 || o.cycles !== 2 || o.wr_cnt !== 0) begin errors++; $display("FAIL d_eq_a_pc: pc=%0h cycles=%0d wr=%0d want 2/2/0", pc, o.cycles, o.wr_cnt); end
  endtask

  task automatic test_mem_write();
    obs_t o, e;
    issue(16'd5, 0, 16'h0, o, e);
    issue(16'hEC10, 0, 16'h0, o, e);
    issue(16'd100, 0, 16'h0, o, e);
    issue(16'hE7C8, 0, 16'h0, o, e);
    checks++; if (o.wr_cnt !== 1) begin errors++; $display("FAIL mwr_count: got %0d want 1", o.wr_cnt); end
    checks++; if (o.wr_addr !== 15'd100 || o.wr_data !== 16'd6) begin errors++; $display("FAIL mwr_data: addr=%0d data=%0d want 100/6", o.wr_addr, o.wr_data); end
    checks++; if (x !== 16'd5 || address_m !== 15'd100) begin errors++; $display("FAIL mwr_regs: D=%0d A=%0d want 5/100", x, address_m); end
  endtask

  task automatic test_jump();
    obs_t o, e;
    logic [14:0] pc_before;
    issue(16'd6, 0, 16'h0, o, e);
    issue(16'hEC10, 0, 16'h0, o, e);
    issue(16'd20, 0, 16'h0, o, e);
    issue(16'hE301, 0, 16'h0, o, e);
    checks++; if (pc !== 15'd20) begin errors++; $display("FAIL jgt_taken: pc=%0d want 20", pc); end
    issue(16'd0, 0, 16'h0, o, e);
    issue(16'hEC10, 0, 16'h0, o, e);
    issue(16'd20, 0, 16'h0, o, e);
    pc_before = pc;
    issue(16'hE301, 0, 16'h0, o, e);
    checks++; if (pc !== pc_before + 15'd1) begin errors++; $display("FAIL jgt_not_taken: pc=%0d want %0d", pc, pc_before + 15'd1); end
  endtask

  task automatic test_mread_stall();
    obs_t o, e;
    issue(16'd7, 0, 16'h0, o, e);
    issue(16'hFCA8, 2, 16'd9, o, e);
    checks++; if (o.rd_cycles !== 3) begin errors++; $display("FAIL mread_hold: mem_rd cycles=%0d want 3", o.rd_cycles); end
    checks++; if (o.wr_cnt !== 1 || o.wr_addr !== 15'd7 || o.wr_data !== 16'd8) begin errors++; $display("FAIL mread_write: n=%0d addr=%0d data=%0d want 1/7/8", o.wr_cnt, o.wr_addr, o.wr_data); end
    checks++; if (address_m !== 15'd8 || o.cycles !== 5) begin errors++; $display("FAIL mread_a: A=%0d cycles=%0d want 8/5", address_m, o.cycles); end
  endtask

  task automatic test_pc_wrap();
    obs_t o, e;
`ifdef HACK_EXEC_PERF_EN
    logic [31:0] cyc0, ret0;
`endif
    issue(16'h7FFF, 0, 16'h0, o, e);
    issue(16'hEA87, 0, 16'h0, o, e);
    checks++; if (pc !== 15'h7FFF) begin errors++; $display("FAIL jmp_top: pc=%0h want 7fff", pc); end
`ifdef HACK_EXEC_PERF_EN
    cyc0 = cyc_cnt;
    ret0 = ret_cnt;
`endif
    issue(16'd1, 0, 16'h0, o, e);
    checks++; if (pc !== 15'd0) begin errors++; $display("FAIL pc_wrap: pc=%0h want 0", pc); end
`ifdef HACK_EXEC_PERF_EN
    checks++; if (ret_cnt !== ret0 + 32'd1) begin errors++; $display("FAIL ret_cnt: got %0d want %0d", ret_cnt, ret0 + 32'd1); end
    checks++; if (cyc_cnt !== cyc0 + 32'(o.cycles)) begin errors++; $display("FAIL cyc_cnt: got %0d want %0d", cyc_cnt, cyc0 + 32'(o.cycles)); end
    cyc0 = cyc_cnt;
    ret0 = ret_cnt;
    issue(16'hFCA8, 1, 16'd3, o, e);
    checks++; if (ret_cnt !== ret0 + 32'd1 || cyc_cnt !== cyc0 + 32'(e.cycles)) begin errors++; $display("FAIL perf_mread: ret=%0d cyc=%0d want %0d/%0d", ret_cnt, cyc_cnt, ret0 + 32'd1, cyc0 + 32'(e.cycles)); end
`endif
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [15:0] ins, mdata;
    logic [30:0] got, want;
    int mdelay;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) ins = {1'b0, 15'($urandom)};
      else                           ins = {1'b1, 15'($urandom)};
      mdelay = $urandom_range(0, 3);
      mdata  = 16'($urandom);
      run_instr(ins, mdelay, mdata, o);
      model_exec(ins, mdelay, mdata, e);
      if (e.wr_cnt == 1) exp_q.push_back({e.wr_addr, e.wr_data});
      checks++; if (o.cycles !== e.cycles || o.rd_cycles !== e.rd_cycles) begin errors++; $display("FAIL rnd_timing[%0d] inst=%04h: cycles=%0d rd=%0d want %0d/%0d", i, ins, o.cycles, o.rd_cycles, e.cycles, e.rd_cycles); end
      checks++;
      if (o.wr_cnt !== e.wr_cnt) begin
        errors++; $display("FAIL rnd_wr_count[%0d] inst=%04h: got %0d want %0d", i, ins, o.wr_cnt, e.wr_cnt);
        exp_q.delete();
      end else if (o.wr_cnt == 1) begin
        got  = {o.wr_addr, o.wr_data};
        want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL rnd_wr_data[%0d]: got %08h want %08h", i, got, want); end
      end
      checks++; if (ins[15] && o.ctl !== e.ctl) begin errors++; $display("FAIL rnd_ctl[%0d]: got %b want %b", i, o.ctl, e.ctl); end
      checks++; if (pc !== mpc || address_m !== ma[14:0] || x !== md) begin errors++; $display("FAIL rnd_regs[%0d] inst=%04h: pc=%0h A=%0h D=%0h want %0h/%0h/%0h", i, ins, pc, address_m, x, mpc, ma[14:0], md); end
      checks++; if (y !== (mir[12] ? mlat : ma)) begin errors++; $display("FAIL rnd_y[%0d]: got %04h want %04h", i, y, mir[12] ? mlat : ma); end
    end
  endtask

  initial begin
    test_reset();
    test_d_eq_a();
    test_mem_write();
    test_jump();
    test_mread_stall();
    test_pc_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
